// File: rtl/aux_native_req_tx_if.sv
// Bundle of de-mux request inputs, PHY handshake and status outputs
// for the native AUX request transmitter.
interface aux_native_req_tx_if;
    logic [1:0]  de_mux_native_cmd;
    logic [7:0]  de_mux_native_data;
    logic [19:0] de_mux_native_address;
    logic [7:0]  de_mux_native_len;
    logic        de_mux_native_tr_vld;
    logic        phy_tx_ready;
    logic [7:0]  native_tx_byte;
    logic        native_tx_vld;
    logic        native_tx_last;
    logic        native_busy;
    logic        native_err;

    // Environment side: de-mux drives the request, PHY drives ready.
    modport master (
        output de_mux_native_cmd, de_mux_native_data, de_mux_native_address,
               de_mux_native_len, de_mux_native_tr_vld, phy_tx_ready,
        input  native_tx_byte, native_tx_vld, native_tx_last,
               native_busy, native_err
    );

    // Transmitter side.
    modport slave (
        input  de_mux_native_cmd, de_mux_native_data, de_mux_native_address,
               de_mux_native_len, de_mux_native_tr_vld, phy_tx_ready,
        output native_tx_byte, native_tx_vld, native_tx_last,
               native_busy, native_err
    );
endinterface

// File: rtl/aux_native_req_tx.sv
// Native AUX request transmitter: latches a native request, buffers up to
// 16 write bytes and streams header + payload to the PHY encoder.
module aux_native_req_tx (
    input  logic              clk,
    input  logic              rst,
    aux_native_req_tx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, COLLECT, HDR0, HDR1, HDR2, HDR3, DATA, FLUSH
    } state_t;

    state_t      state, state_next;

    // Holding registers for the request being sent.
    logic        rd_q;
    logic [19:0] addr_q;
    logic [7:0]  len_q;

    // Payload FIFO.
    logic [7:0]  mem [0:15];
    logic [3:0]  wr_ptr, rd_ptr;
    logic [4:0]  count;

    logic        err_q;
    logic        vld_prev;
    logic        hdr_entry;

    logic        latch, push, pop, clr, err_set, fire;
    logic [7:0]  tx_byte;
    logic        tx_vld, tx_last;
    logic        in_tx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clr        = 1'b0;
        err_set    = 1'b0;
        fire       = tx_vld && bus.phy_tx_ready;
        in_tx      = (state == HDR0) || (state == HDR1) || (state == HDR2) ||
                     (state == HDR3) || (state == DATA);
        case (state)
            IDLE: begin
                if (bus.de_mux_native_tr_vld) begin
                    latch = 1'b1;
                    if (bus.de_mux_native_cmd[1] || (bus.de_mux_native_len > 8'd15)) begin
                        err_set    = 1'b1;
                        state_next = FLUSH;
                    end else if (bus.de_mux_native_cmd[0]) begin
                        state_next = HDR0;
                    end else begin
                        push       = 1'b1;
                        state_next = (bus.de_mux_native_len == 8'd0) ? HDR0 : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.de_mux_native_tr_vld) begin
                    push = 1'b1;
                    // count already holds the bytes pushed so far; this push is byte count+1
                    if (count == len_q[4:0]) state_next = HDR0;
                end else begin
                    // burst ended short: drop the partial payload
                    clr        = 1'b1;
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            HDR0: if (fire) state_next = HDR1;
            HDR1: if (fire) state_next = HDR2;
            HDR2: if (fire) state_next = HDR3;
            HDR3: if (fire) state_next = rd_q ? IDLE : DATA;
            DATA: begin
                if (fire) begin
                    pop = 1'b1;
                    if (count == 5'd1) state_next = IDLE;
                end
            end
            FLUSH: if (!bus.de_mux_native_tr_vld) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // New burst while sending, or a burst that runs past its length.
        if (in_tx && bus.de_mux_native_tr_vld && (!vld_prev || hdr_entry))
            err_set = 1'b1;
    end

    // Output decode, purely from registered state.
    always_comb begin
        tx_byte = 8'h00;
        tx_vld  = 1'b0;
        tx_last = 1'b0;
        case (state)
            HDR0: begin tx_vld = 1'b1; tx_byte = {3'b100, rd_q, addr_q[19:16]}; end
            HDR1: begin tx_vld = 1'b1; tx_byte = addr_q[15:8]; end
            HDR2: begin tx_vld = 1'b1; tx_byte = addr_q[7:0]; end
            HDR3: begin tx_vld = 1'b1; tx_byte = len_q; tx_last = rd_q; end
            DATA: begin tx_vld = 1'b1; tx_byte = mem[rd_ptr]; tx_last = (count == 5'd1); end
            default: ;
        endcase
    end

    // Holding registers, FIFO pointers and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_q     <= 1'b0;
            vld_prev  <= 1'b0;
            hdr_entry <= 1'b0;
        end else begin
            err_q     <= err_set;
            vld_prev  <= bus.de_mux_native_tr_vld;
            hdr_entry <= (state_next == HDR0) && (state != HDR0);
            if (latch) begin
                rd_q   <= bus.de_mux_native_cmd[0];
                addr_q <= bus.de_mux_native_address;
                len_q  <= bus.de_mux_native_len;
            end
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 4'd1;
                if (pop)  rd_ptr <= rd_ptr + 4'd1;
                case ({push, pop})
                    2'b10:   count <= count + 5'd1;
                    2'b01:   count <= count - 5'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage; emptiness is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.de_mux_native_data;
    end

    assign bus.native_tx_byte = tx_byte;
    assign bus.native_tx_vld  = tx_vld;
    assign bus.native_tx_last = tx_last;
    assign bus.native_busy    = (state != IDLE);
    assign bus.native_err     = err_q;
endmodule

// File: tb/tb_aux_native_req_tx.sv
// Directed bench for aux_native_req_tx: reads, writes, backpressure,
// error paths, FIFO wrap with back-to-back read, and mid-request reset.
module tb_aux_native_req_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aux_native_req_tx_if bus();
    aux_native_req_tx dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] cap_byte [32];
    logic       cap_last [32];
    int         cap_n, cap_unstable, cap_gap, cap_busy, cap_first;
    bit         cap_timeout;
    logic [7:0] exp_b [32];
    int         exp_n;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drive one contiguous tr_vld burst of nbytes; data steps by 0x11 from d0.
    task automatic send(input logic [1:0] cmd, input logic [19:0] addr,
                        input logic [7:0] len, input int nbytes, input logic [7:0] d0);
        for (int i = 0; i < nbytes; i++) begin
            bus.de_mux_native_cmd     = cmd;
            bus.de_mux_native_address = addr;
            bus.de_mux_native_len     = len;
            bus.de_mux_native_data    = d0 + 8'(i * 17);
            bus.de_mux_native_tr_vld  = 1'b1;
            tick();
        end
        bus.de_mux_native_tr_vld = 1'b0;
        bus.de_mux_native_data   = 8'h00;
    endtask

    // Record accepted bytes until the last one; ready is 1,0,0,... when bp set.
    task automatic capture(input bit bp, input int max_cyc);
        int cyc = 0;
        int ph = 0;
        bit done = 0;
        bit hold = 0;
        logic [7:0] pb = 8'h00;
        logic pl = 1'b0;
        logic rdy;
        cap_n = 0; cap_unstable = 0; cap_gap = 0; cap_busy = 0; cap_first = -1;
        while (!done && cyc < max_cyc) begin
            if (bus.native_busy) cap_busy++;
            if (bus.native_tx_vld) begin
                if (cap_first < 0) cap_first = cyc;
                if (hold && (bus.native_tx_byte !== pb || bus.native_tx_last !== pl))
                    cap_unstable++;
            end else if (cap_first >= 0) begin
                cap_gap++;
            end
            rdy = bp ? ((ph % 3) == 0) : 1'b1;
            ph++;
            bus.phy_tx_ready = rdy;
            if (bus.native_tx_vld && rdy) begin
                if (cap_n < 32) begin
                    cap_byte[cap_n] = bus.native_tx_byte;
                    cap_last[cap_n] = bus.native_tx_last;
                end
                cap_n++;
                hold = 0;
                if (bus.native_tx_last) done = 1;
            end else if (bus.native_tx_vld) begin
                hold = 1;
                pb = bus.native_tx_byte;
                pl = bus.native_tx_last;
            end
            tick();
            cyc++;
        end
        bus.phy_tx_ready = 1'b1;
        cap_timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++; if (bus.native_tx_byte !== 8'h00) begin $display("FAIL reset_byte got %0h want 0", bus.native_tx_byte); n_fail++; end
        n_chk++; if (bus.native_tx_vld  !== 1'b0)  begin $display("FAIL reset_vld got %0b want 0", bus.native_tx_vld); n_fail++; end
        n_chk++; if (bus.native_tx_last !== 1'b0)  begin $display("FAIL reset_last got %0b want 0", bus.native_tx_last); n_fail++; end
        n_chk++; if (bus.native_busy    !== 1'b0)  begin $display("FAIL reset_busy got %0b want 0", bus.native_busy); n_fail++; end
        n_chk++; if (bus.native_err     !== 1'b0)  begin $display("FAIL reset_err got %0b want 0", bus.native_err); n_fail++; end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        exp_n = 4;
        exp_b[0] = 8'h90; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h0F;
        send(2'b01, 20'h00102, 8'h0F, 1, 8'h00);
        capture(1'b0, 20);
        n_chk++; if (cap_timeout) begin $display("FAIL read_timeout got timeout want last"); n_fail++; end
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL read_count got %0d want %0d", cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL read_byte%0d got %0h want %0h", i, cap_byte[i], exp_b[i]); n_fail++; end
            n_chk++; if (cap_last[i] !== (i == exp_n - 1)) begin $display("FAIL read_last%0d got %0b", i, cap_last[i]); n_fail++; end
        end
        n_chk++; if (cap_first !== 0) begin $display("FAIL read_latency got %0d want 0", cap_first); n_fail++; end
        n_chk++; if (cap_busy !== 4) begin $display("FAIL read_busy_cycles got %0d want 4", cap_busy); n_fail++; end
        n_chk++; if (bus.native_busy !== 1'b0) begin $display("FAIL read_busy_after got %0b want 0", bus.native_busy); n_fail++; end
    endtask

    task automatic test_write(input bit bp);
        exp_n = 7;
        exp_b[0] = 8'h8F; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h02;
        exp_b[4] = 8'hA1; exp_b[5] = 8'hB2; exp_b[6] = 8'hC3;
        send(2'b00, 20'hF1234, 8'h02, 3, 8'hA1);
        capture(bp, 60);
        n_chk++; if (cap_timeout) begin $display("FAIL write_timeout bp=%0b got timeout want last", bp); n_fail++; end
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL write_count bp=%0b got %0d want %0d", bp, cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL write_byte%0d bp=%0b got %0h want %0h", i, bp, cap_byte[i], exp_b[i]); n_fail++; end
            n_chk++; if (cap_last[i] !== (i == exp_n - 1)) begin $display("FAIL write_last%0d bp=%0b got %0b", i, bp, cap_last[i]); n_fail++; end
        end
        n_chk++; if (cap_first !== 0) begin $display("FAIL write_latency bp=%0b got %0d want 0", bp, cap_first); n_fail++; end
        n_chk++; if (cap_unstable !== 0) begin $display("FAIL write_stable bp=%0b got %0d changes want 0", bp, cap_unstable); n_fail++; end
        n_chk++; if (cap_gap !== 0) begin $display("FAIL write_vld_gap bp=%0b got %0d want 0", bp, cap_gap); n_fail++; end
        if (!bp) begin
            n_chk++; if (cap_busy !== 7) begin $display("FAIL write_busy_cycles got %0d want 7", cap_busy); n_fail++; end
        end
    endtask

    task automatic test_err_cmd();
        bus.de_mux_native_cmd    = 2'b10;
        bus.de_mux_native_len    = 8'h01;
        bus.de_mux_native_tr_vld = 1'b1;
        tick();
        bus.de_mux_native_tr_vld = 1'b0;
        n_chk++; if (bus.native_err !== 1'b1) begin $display("FAIL errcmd_pulse got %0b want 1", bus.native_err); n_fail++; end
        n_chk++; if (bus.native_tx_vld !== 1'b0) begin $display("FAIL errcmd_vld got %0b want 0", bus.native_tx_vld); n_fail++; end
        tick();
        n_chk++; if (bus.native_err !== 1'b0) begin $display("FAIL errcmd_pulse_width got %0b want 0", bus.native_err); n_fail++; end
        n_chk++; if (bus.native_busy !== 1'b0) begin $display("FAIL errcmd_idle got busy %0b want 0", bus.native_busy); n_fail++; end
    endtask

    task automatic test_err_len();
        int errs = 0;
        int vlds = 0;
        logic first_err = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.de_mux_native_cmd     = 2'b00;
            bus.de_mux_native_address = 20'h00050;
            bus.de_mux_native_len     = 8'd16;
            bus.de_mux_native_data    = 8'(i);
            bus.de_mux_native_tr_vld  = 1'b1;
            tick();
            if (i == 0) first_err = bus.native_err;
            if (bus.native_err) errs++;
            if (bus.native_tx_vld) vlds++;
        end
        bus.de_mux_native_tr_vld = 1'b0;
        tick();
        if (bus.native_err) errs++;
        if (bus.native_tx_vld) vlds++;
        n_chk++; if (first_err !== 1'b1) begin $display("FAIL errlen_first got %0b want 1", first_err); n_fail++; end
        n_chk++; if (errs !== 1) begin $display("FAIL errlen_pulses got %0d want 1", errs); n_fail++; end
        n_chk++; if (vlds !== 0) begin $display("FAIL errlen_vld got %0d want 0", vlds); n_fail++; end
        n_chk++; if (bus.native_busy !== 1'b0) begin $display("FAIL errlen_idle got busy %0b want 0", bus.native_busy); n_fail++; end
    endtask

    task automatic test_err_drop();
        send(2'b00, 20'h00300, 8'h03, 2, 8'h77);
        n_chk++; if (bus.native_err !== 1'b0) begin $display("FAIL errdrop_early got %0b want 0", bus.native_err); n_fail++; end
        tick();
        n_chk++; if (bus.native_err !== 1'b1) begin $display("FAIL errdrop_pulse got %0b want 1", bus.native_err); n_fail++; end
        n_chk++; if (bus.native_busy !== 1'b0) begin $display("FAIL errdrop_idle got busy %0b want 0", bus.native_busy); n_fail++; end
        n_chk++; if (bus.native_tx_vld !== 1'b0) begin $display("FAIL errdrop_vld got %0b want 0", bus.native_tx_vld); n_fail++; end
        tick();
        n_chk++; if (bus.native_err !== 1'b0) begin $display("FAIL errdrop_width got %0b want 0", bus.native_err); n_fail++; end
        // A leftover 0x77/0x88 in the FIFO would show up ahead of 0x5A.
        exp_n = 5;
        exp_b[0] = 8'h80; exp_b[1] = 8'h00; exp_b[2] = 8'h10; exp_b[3] = 8'h00; exp_b[4] = 8'h5A;
        send(2'b00, 20'h00010, 8'h00, 1, 8'h5A);
        capture(1'b0, 20);
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL errdrop_next_count got %0d want %0d", cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL errdrop_next_byte%0d got %0h want %0h", i, cap_byte[i], exp_b[i]); n_fail++; end
        end
    endtask

    task automatic test_back_to_back();
        exp_n = 20;
        exp_b[0] = 8'h80; exp_b[1] = 8'h02; exp_b[2] = 8'h00; exp_b[3] = 8'h0F;
        for (int i = 0; i < 16; i++) exp_b[4 + i] = 8'h10 + 8'(i * 17);
        send(2'b00, 20'h00200, 8'h0F, 16, 8'h10);
        capture(1'b0, 60);
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL wrap_count got %0d want %0d", cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL wrap_byte%0d got %0h want %0h", i, cap_byte[i], exp_b[i]); n_fail++; end
            n_chk++; if (cap_last[i] !== (i == exp_n - 1)) begin $display("FAIL wrap_last%0d got %0b", i, cap_last[i]); n_fail++; end
        end
        n_chk++; if (bus.native_busy !== 1'b0) begin $display("FAIL wrap_busy_after got %0b want 0", bus.native_busy); n_fail++; end
        // Read starts in the first IDLE cycle.
        exp_n = 4;
        exp_b[0] = 8'h9A; exp_b[1] = 8'hBC; exp_b[2] = 8'hDE; exp_b[3] = 8'h03;
        send(2'b01, 20'hABCDE, 8'h03, 1, 8'h00);
        capture(1'b0, 20);
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL b2b_count got %0d want %0d", cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL b2b_byte%0d got %0h want %0h", i, cap_byte[i], exp_b[i]); n_fail++; end
        end
        n_chk++; if (cap_first !== 0) begin $display("FAIL b2b_latency got %0d want 0", cap_first); n_fail++; end
    endtask

    task automatic test_rst_mid();
        send(2'b00, 20'h00400, 8'h03, 4, 8'h01);
        bus.phy_tx_ready = 1'b1;
        repeat (5) tick();
        n_chk++; if (bus.native_tx_vld !== 1'b1) begin $display("FAIL rstmid_in_data got vld %0b want 1", bus.native_tx_vld); n_fail++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (bus.native_tx_vld  !== 1'b0)  begin $display("FAIL rstmid_vld got %0b want 0", bus.native_tx_vld); n_fail++; end
        n_chk++; if (bus.native_tx_byte !== 8'h00) begin $display("FAIL rstmid_byte got %0h want 0", bus.native_tx_byte); n_fail++; end
        n_chk++; if (bus.native_tx_last !== 1'b0)  begin $display("FAIL rstmid_last got %0b want 0", bus.native_tx_last); n_fail++; end
        n_chk++; if (bus.native_busy    !== 1'b0)  begin $display("FAIL rstmid_busy got %0b want 0", bus.native_busy); n_fail++; end
        n_chk++; if (bus.native_err     !== 1'b0)  begin $display("FAIL rstmid_err got %0b want 0", bus.native_err); n_fail++; end
        exp_n = 4;
        exp_b[0] = 8'h90; exp_b[1] = 8'h00; exp_b[2] = 8'h05; exp_b[3] = 8'h00;
        send(2'b01, 20'h00005, 8'h00, 1, 8'h00);
        capture(1'b0, 20);
        n_chk++; if (cap_n !== exp_n) begin $display("FAIL rstmid_read_count got %0d want %0d", cap_n, exp_n); n_fail++; end
        for (int i = 0; i < exp_n; i++) begin
            n_chk++; if (cap_byte[i] !== exp_b[i]) begin $display("FAIL rstmid_read_byte%0d got %0h want %0h", i, cap_byte[i], exp_b[i]); n_fail++; end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.de_mux_native_cmd     = 2'b00;
        bus.de_mux_native_data    = 8'h00;
        bus.de_mux_native_address = 20'h00000;
        bus.de_mux_native_len     = 8'h00;
        bus.de_mux_native_tr_vld  = 1'b0;
        bus.phy_tx_ready          = 1'b1;
        test_reset();
        test_read();
        test_write(1'b0);
        test_write(1'b1);
        test_err_cmd();
        test_err_len();
        test_err_drop();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
